// File: rtl/ssd_pkg.sv
// Shared types and constants for the keypad-entry seven-segment display driver.
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      HOLDOFF
   } entry_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Segment order {g,f,e,d,c,b,a}, active-high, indexed by hex value.
   localparam logic [6:0] HEX_TO_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/ssd_entry_driver_if.sv
// Keypad-side inputs and display-side outputs of the entry driver.
interface ssd_entry_driver_if;

   logic [3:0] key_code;
   logic       key_down;
   logic       clear;
   logic [6:0] seg;
   logic       chip_sel;
   logic [7:0] digits;
   logic [1:0] entry_count;
   logic       new_key;

   modport master (
      output key_code, key_down, clear,
      input  seg, chip_sel, digits, entry_count, new_key
   );

   modport slave (
      input  key_code, key_down, clear,
      output seg, chip_sel, digits, entry_count, new_key
   );

endinterface

// File: rtl/seg_encoder.sv
// Hex value to seven-segment pattern, forced dark when the digit is not valid.
module seg_encoder
   import ssd_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_BLANK : HEX_TO_SEG[value];

endmodule

// File: rtl/ssd_entry_driver.sv
// Turns keypad decoder levels into discrete key entries, keeps the last two,
// and multiplexes them onto a dual-digit seven-segment display.
module ssd_entry_driver
   import ssd_pkg::*;
#(
   parameter int CLK_FREQ       = 125_000_000,
   parameter int REFRESH_HZ     = 200,
   parameter int HOLDOFF_CYCLES = 2_500_000
) (
   input  logic clk,
   input  logic rst,
   ssd_entry_driver_if.slave bus
);

   localparam int TOGGLE = CLK_FREQ / (2 * REFRESH_HZ);
   localparam int RW     = $clog2(TOGGLE);
   localparam int HW     = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   localparam logic [RW-1:0] TOGGLE_LAST = RW'(TOGGLE - 1);
   localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLDOFF_CYCLES - 1);

   entry_state_t    state;
   logic [HW-1:0]   holdoff;
   logic            key_down_q;
   logic [3:0]      digit0;
   logic [3:0]      digit1;
   logic [1:0]      count;
   logic            new_key_q;

   logic [RW-1:0]   refresh_cnt;
   logic            chip_sel_q;
   logic [6:0]      seg_q;

   logic            rise;
   logic            accept;
   logic            toggle;
   logic            next_chip_sel;
   logic [3:0]      sel_value;
   logic            sel_blank;
   logic [6:0]      seg_next;

   assign rise   = bus.key_down & ~key_down_q;
   assign accept = (state == IDLE) & rise;

   // Entry FSM plus the digit buffer it feeds; clear overrides a same-cycle
   // accept but the FSM still advances so that press is consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         holdoff    <= '0;
         key_down_q <= 1'b0;
         digit0     <= 4'h0;
         digit1     <= 4'h0;
         count      <= 2'd0;
         new_key_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register in this block
         // sees pre-edge values, e.g. digit1 takes the old digit0.
         key_down_q <= bus.key_down;
         new_key_q  <= accept & ~bus.clear;

         unique case (state)
            IDLE: begin
               if (rise) state <= PRESSED;
            end
            PRESSED: begin
               if (!bus.key_down) begin
                  holdoff <= HOLD_LOAD;
                  state   <= HOLDOFF;
               end
            end
            HOLDOFF: begin
               if (holdoff == '0) state <= IDLE;
               else               holdoff <= holdoff - HW'(1);
            end
            default: state <= IDLE;
         endcase

         if (bus.clear) begin
            digit0 <= 4'h0;
            digit1 <= 4'h0;
            count  <= 2'd0;
         end else if (accept) begin
            digit1 <= digit0;
            digit0 <= bus.key_code;
            if (count != 2'd2) count <= count + 2'd1;
         end
      end
   end

   assign toggle        = (refresh_cnt == TOGGLE_LAST);
   assign next_chip_sel = chip_sel_q ^ toggle;

   // NOTE: both outputs get a default first, so no path leaves them unassigned
   // and no latch is inferred.
   always_comb begin
      sel_value = digit0;
      sel_blank = (count == 2'd0);
      if (next_chip_sel) begin
         sel_value = digit1;
         sel_blank = (count != 2'd2);
      end
   end

   seg_encoder u_seg_encoder (
      .value (sel_value),
      .blank (sel_blank),
      .seg   (seg_next)
   );

   // seg is computed from the upcoming chip_sel so both change on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_cnt <= '0;
         chip_sel_q  <= 1'b0;
         seg_q       <= SEG_BLANK;
      end else begin
         refresh_cnt <= toggle ? '0 : refresh_cnt + RW'(1);
         chip_sel_q  <= next_chip_sel;
         seg_q       <= seg_next;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.chip_sel    = chip_sel_q;
   assign bus.digits      = {digit1, digit0};
   assign bus.entry_count = count;
   assign bus.new_key     = new_key_q;

endmodule

// File: tb/tb_ssd_entry_driver.sv
// Self-checking bench for ssd_entry_driver: directed scenarios plus random key
// activity, all compared against a timestamp/queue model of the entry rules.
module tb_ssd_entry_driver;

   localparam int CLK_FREQ   = 1000;
   localparam int REFRESH_HZ = 100;
   localparam int HOLDOFF    = 4;
   localparam int TOGGLE     = CLK_FREQ / (2 * REFRESH_HZ);

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic clk = 1'b0;
   logic rst = 1'b1;

   ssd_entry_driver_if bus ();

   ssd_entry_driver #(
      .CLK_FREQ       (CLK_FREQ),
      .REFRESH_HZ     (REFRESH_HZ),
      .HOLDOFF_CYCLES (HOLDOFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [18:0] act;
   assign act = {bus.seg, bus.chip_sel, bus.digits, bus.entry_count, bus.new_key};

   int n_vec = 0;
   int n_err = 0;

   // Reference model: entries are a queue of accepted keys; lock-out is
   // expressed as "pressed, awaiting release" plus the edge number of release.
   int          edge_n;
   bit          kd_prev;
   bit          in_press;
   int          release_edge;
   logic [3:0]  hist [$];
   logic [6:0]  m_seg;
   bit          m_cs;
   bit          m_nk;
   int          m_acc;

   int          nk_seen;
   int          sb_bad;
   logic [18:0] sb_got;
   logic [18:0] sb_want;

   function automatic logic [7:0] m_digits();
      if (hist.size() == 0) return 8'h00;
      if (hist.size() == 1) return {4'h0, hist[0]};
      return {hist[0], hist[1]};
   endfunction

   function automatic logic [1:0] m_count();
      return 2'(hist.size());
   endfunction

   function automatic logic [18:0] exp_vec();
      return {m_seg, m_cs, m_digits(), m_count(), m_nk};
   endfunction

   task automatic model_reset();
      edge_n       = 0;
      kd_prev      = 1'b0;
      in_press     = 1'b0;
      release_edge = -100;
      hist.delete();
      m_seg        = 7'h00;
      m_cs         = 1'b0;
      m_nk         = 1'b0;
   endtask

   task automatic model_edge();
      logic [7:0] old_d;
      int         old_n;
      bit         kd;
      bit         rise;
      kd    = bus.key_down;
      old_d = m_digits();
      old_n = hist.size();
      edge_n++;
      rise  = kd && !kd_prev;
      m_nk  = 1'b0;
      if (in_press) begin
         if (!kd) begin
            in_press     = 1'b0;
            release_edge = edge_n;
         end
      end else if (rise && edge_n >= release_edge + HOLDOFF + 1) begin
         in_press = 1'b1;
         if (!bus.clear) begin
            hist.push_back(bus.key_code);
            if (hist.size() > 2) void'(hist.pop_front());
            m_nk = 1'b1;
            m_acc++;
         end
      end
      if (bus.clear) hist.delete();
      m_cs = ((edge_n / TOGGLE) % 2) == 1;
      if (m_cs) m_seg = (old_n == 2) ? SEG_TABLE[old_d[7:4]] : 7'h00;
      else      m_seg = (old_n >= 1) ? SEG_TABLE[old_d[3:0]] : 7'h00;
      kd_prev = kd;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (bus.new_key) nk_seen++;
      if (act !== exp_vec()) begin
         sb_bad++;
         sb_got  = act;
         sb_want = exp_vec();
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold, input int gap);
      bus.key_code = code;
      bus.key_down = 1'b1;
      repeat (hold) tick();
      bus.key_down = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if (act !== 19'h0) begin
         n_err++;
         $display("FAIL reset_outputs got %h expected %h", act, 19'h0);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_refresh_idle();
      int  toggles;
      int  lit;
      logic prev_cs;
      toggles = 0;
      lit     = 0;
      sb_bad  = 0;
      prev_cs = bus.chip_sel;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.chip_sel !== prev_cs) toggles++;
         if (bus.seg !== 7'h00) lit++;
         prev_cs = bus.chip_sel;
      end
      n_vec++;
      if (toggles != 4) begin
         n_err++;
         $display("FAIL idle_toggles got %0d expected %0d", toggles, 4);
      end
      n_vec++;
      if (lit != 0) begin
         n_err++;
         $display("FAIL idle_blank got %0d lit cycles expected %0d", lit, 0);
      end
      n_vec++;
      if (sb_bad != 0) begin
         n_err++;
         $display("FAIL idle_trace %0d cycles off, last got %h expected %h", sb_bad, sb_got, sb_want);
      end
      sb_bad = 0;
   endtask

   task automatic test_single_key();
      int bad_seg;
      nk_seen = 0;
      press(4'h5, 3, HOLDOFF + 2);
      n_vec++;
      if (nk_seen != 1) begin
         n_err++;
         $display("FAIL single_new_key got %0d pulses expected %0d", nk_seen, 1);
      end
      n_vec++;
      if ({bus.digits, bus.entry_count} !== {8'h05, 2'd1}) begin
         n_err++;
         $display("FAIL single_digits got %h/%0d expected 05/1", bus.digits, bus.entry_count);
      end
      bad_seg = 0;
      for (int i = 0; i < 2 * TOGGLE; i++) begin
         tick();
         if (bus.seg !== (bus.chip_sel ? 7'h00 : 7'h6D)) bad_seg++;
      end
      n_vec++;
      if (bad_seg != 0) begin
         n_err++;
         $display("FAIL single_seg got %0d wrong cycles expected %0d", bad_seg, 0);
      end
      n_vec++;
      if (sb_bad != 0) begin
         n_err++;
         $display("FAIL single_trace %0d cycles off, last got %h expected %h", sb_bad, sb_got, sb_want);
      end
      sb_bad = 0;
   endtask

   task automatic test_two_keys();
      int bad_seg;
      pulse_clear();
      nk_seen = 0;
      press(4'h5, 2, HOLDOFF + 2);
      press(4'hA, 2, HOLDOFF + 2);
      n_vec++;
      if ({bus.digits, bus.entry_count} !== {8'h5A, 2'd2} || nk_seen != 2) begin
         n_err++;
         $display("FAIL two_keys got %h/%0d/%0d expected 5a/2/2", bus.digits, bus.entry_count, nk_seen);
      end
      bad_seg = 0;
      for (int i = 0; i < 2 * TOGGLE; i++) begin
         tick();
         if (bus.seg !== (bus.chip_sel ? 7'h6D : 7'h77)) bad_seg++;
      end
      n_vec++;
      if (bad_seg != 0) begin
         n_err++;
         $display("FAIL two_keys_seg got %0d wrong cycles expected %0d", bad_seg, 0);
      end
      press(4'h3, 2, HOLDOFF + 2);
      n_vec++;
      if ({bus.digits, bus.entry_count} !== {8'hA3, 2'd2}) begin
         n_err++;
         $display("FAIL third_key got %h/%0d expected a3/2", bus.digits, bus.entry_count);
      end
      n_vec++;
      if (sb_bad != 0) begin
         n_err++;
         $display("FAIL two_keys_trace %0d cycles off, last got %h expected %h", sb_bad, sb_got, sb_want);
      end
      sb_bad = 0;
   endtask

   task automatic test_bounce();
      pulse_clear();
      nk_seen = 0;
      bus.key_code = 4'h9;
      bus.key_down = 1'b1;
      repeat (2) tick();
      bus.key_down = 1'b0;
      tick();
      bus.key_code = 4'h6;
      bus.key_down = 1'b1;
      repeat (HOLDOFF + 6) tick();
      n_vec++;
      if (nk_seen != 1 || bus.digits !== 8'h09) begin
         n_err++;
         $display("FAIL bounce_ignored got %0d/%h expected 1/09", nk_seen, bus.digits);
      end
      bus.key_down = 1'b0;
      repeat (HOLDOFF + 2) tick();
      press(4'h2, 2, HOLDOFF + 2);
      n_vec++;
      if ({bus.digits, bus.entry_count} !== {8'h92, 2'd2} || nk_seen != 2) begin
         n_err++;
         $display("FAIL bounce_repress got %h/%0d/%0d expected 92/2/2", bus.digits, bus.entry_count, nk_seen);
      end
      n_vec++;
      if (sb_bad != 0) begin
         n_err++;
         $display("FAIL bounce_trace %0d cycles off, last got %h expected %h", sb_bad, sb_got, sb_want);
      end
      sb_bad = 0;
   endtask

   task automatic test_clear_collision();
      nk_seen = 0;
      bus.key_code = 4'h7;
      bus.key_down = 1'b1;
      bus.clear    = 1'b1;
      tick();
      bus.clear    = 1'b0;
      n_vec++;
      if ({bus.digits, bus.entry_count} !== {8'h00, 2'd0}) begin
         n_err++;
         $display("FAIL clear_wins got %h/%0d expected 00/0", bus.digits, bus.entry_count);
      end
      repeat (3) tick();
      bus.key_down = 1'b0;
      repeat (HOLDOFF + 2) tick();
      n_vec++;
      if (nk_seen != 0 || {bus.digits, bus.entry_count} !== {8'h00, 2'd0}) begin
         n_err++;
         $display("FAIL clear_no_entry got %0d/%h/%0d expected 0/00/0", nk_seen, bus.digits, bus.entry_count);
      end
      n_vec++;
      if (sb_bad != 0) begin
         n_err++;
         $display("FAIL clear_trace %0d cycles off, last got %h expected %h", sb_bad, sb_got, sb_want);
      end
      sb_bad = 0;
   endtask

   task automatic test_async_reset();
      press(4'h1, 2, HOLDOFF + 2);
      press(4'h4, 2, HOLDOFF + 2);
      bus.key_code = 4'h8;
      bus.key_down = 1'b1;
      repeat (2) tick();
      n_vec++;
      if ({bus.digits, bus.entry_count} !== {8'h48, 2'd2}) begin
         n_err++;
         $display("FAIL pre_reset got %h/%0d expected 48/2", bus.digits, bus.entry_count);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (act !== 19'h0) begin
         n_err++;
         $display("FAIL async_reset got %h expected %h", act, 19'h0);
      end
      bus.key_down = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (TOGGLE - 1) tick();
      n_vec++;
      if (bus.chip_sel !== 1'b0) begin
         n_err++;
         $display("FAIL restart_cs_low got %b expected 0", bus.chip_sel);
      end
      tick();
      n_vec++;
      if (bus.chip_sel !== 1'b1) begin
         n_err++;
         $display("FAIL restart_cs_toggle got %b expected 1", bus.chip_sel);
      end
      repeat (10) tick();
      n_vec++;
      if (sb_bad != 0) begin
         n_err++;
         $display("FAIL reset_trace %0d cycles off, last got %h expected %h", sb_bad, sb_got, sb_want);
      end
      sb_bad = 0;
   endtask

   task automatic test_random();
      nk_seen = 0;
      m_acc   = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) bus.key_down = ~bus.key_down;
         bus.key_code = 4'($urandom);
         bus.clear    = ($urandom_range(0, 39) == 0);
         tick();
      end
      bus.key_down = 1'b0;
      bus.clear    = 1'b0;
      repeat (HOLDOFF + 2) tick();
      n_vec++;
      if (nk_seen != m_acc) begin
         n_err++;
         $display("FAIL random_accepts got %0d expected %0d", nk_seen, m_acc);
      end
      n_vec++;
      if (sb_bad != 0) begin
         n_err++;
         $display("FAIL random_trace %0d cycles off, last got %h expected %h", sb_bad, sb_got, sb_want);
      end
      sb_bad = 0;
   endtask

   initial begin
      bus.key_code = 4'h0;
      bus.key_down = 1'b0;
      bus.clear    = 1'b0;
      nk_seen      = 0;
      sb_bad       = 0;
      m_acc        = 0;
      model_reset();
      test_reset();
      test_refresh_idle();
      test_single_key();
      test_two_keys();
      test_bounce();
      test_clear_collision();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ssd_entry_driver.md
Name: ssd_entry_driver

Overview:
- Display-side consumer of the keypad decoder output: turns decoder code/key-down levels into discrete key entries and stores the last two in a 2-digit shift buffer.
- Time-multiplexes both digits onto the dual-digit seven-segment display through the shared segment bus and chip_sel.
- Sits between the keypad decoder and the SSD pins in the top level.
- Replaces the manual button-toggled chip select with an automatic refresh.

Parameters:
- CLK_FREQ, 125_000_000, input clock frequency in Hz.
- REFRESH_HZ, 200, full two-digit refresh rate. Toggle period TOGGLE = CLK_FREQ/(2*REFRESH_HZ) cycles; must be >= 2.
- HOLDOFF_CYCLES, 2_500_000, post-release ignore window in cycles (20 ms at default clock); must be >= 1.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset: asynchronous, active-high.
- key_code, in, 4, hex code of the current key from the keypad decoder (clk domain).
- key_down, in, 1, level; high while the decoder reports a pressed key (clk domain).
- clear, in, 1, synchronous single-cycle pulse; empties the buffer.
- seg, out, 7, segments {g,f,e,d,c,b,a}, active-high.
- chip_sel, out, 1, digit select: 0 = digit0 (right, newest), 1 = digit1 (left, older).
- digits, out, 8, {digit1, digit0} buffer contents.
- entry_count, out, 2, number of valid digits, 0..2, saturating.
- new_key, out, 1, one-cycle pulse, the cycle after an entry is accepted.

Behaviour:
- Reset (async, all state): seg=0, chip_sel=0, digits=0, entry_count=0, new_key=0, FSM=IDLE, refresh and holdoff counters=0, key_down_q=0.
- Edge detect: key_down_q registers key_down; rise = key_down & ~key_down_q.
- Entry FSM:
  - IDLE: on rise, accept key_code, go to PRESSED.
  - PRESSED: wait while key_down=1; on key_down=0, load holdoff=HOLDOFF_CYCLES-1 and go to HOLDOFF.
  - HOLDOFF: decrement each cycle; at 0 go to IDLE. Any key_down activity during HOLDOFF is ignored.
  - A key still held when IDLE is re-entered is not accepted; a fresh rise is required.
- Accept (registered, same edge): digit1<=digit0, digit0<=key_code, entry_count<=min(entry_count+1,2), new_key=1 in the following cycle only.
- clear: digits<=0, entry_count<=0; FSM state is not changed.
  - If clear and accept occur in the same cycle, clear wins and the key is discarded. The FSM still moves to PRESSED, so the same press is not accepted twice.
- Refresh:
  - Counter runs 0..TOGGLE-1 continuously from reset. At TOGGLE-1 it wraps to 0 and chip_sel inverts.
  - seg and chip_sel are both registered and update on the same edge. seg always encodes the digit selected by the new chip_sel value.
- Blanking: a digit position is blank (seg=0) unless valid. Digit0 is valid when entry_count>=1; digit1 is valid when entry_count==2.
- Latency: after an accept or clear edge, seg reflects the new contents by the next cycle (1-cycle registered path); no need to wait for a toggle.
- Encoding (hex -> seg):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Width rules: counters sized with $clog2 of their terminal values. entry_count saturates at 2 and never wraps.

Decomposition:
- Shared package ssd_pkg:
  - entry FSM state enum {IDLE, PRESSED, HOLDOFF};
  - 16-entry hex-to-segment constant array;
  - SEG_BLANK = 7'h00.
- One sub-module: seg_encoder (combinational, 4-bit value plus blank flag -> 7-bit seg), instanced once on the selected-digit path.

Test Plan (bench params CLK_FREQ=1000, REFRESH_HZ=100 giving TOGGLE=5; HOLDOFF_CYCLES=4):
1. Reset, then idle 20 cycles -> chip_sel toggles every 5 cycles; seg=00 throughout (blank); digits=00; entry_count=0.
2. Press key_code=5 (key_down high 3 cycles) -> new_key pulses once; digits=05, entry_count=1; seg=6D while chip_sel=0 and 00 while chip_sel=1.
3. Enter 5 then A, each with full release and holdoff -> digits=5A, entry_count=2; seg=77 with chip_sel=0 and 6D with chip_sel=1. Third key 3 -> digits=A3, entry_count stays 2.
4. Bounce: release, then re-raise key_down within 2 cycles and hold -> no second accept. After holdoff expires with the key still held, still no accept. Release and press again -> accepted.
5. Assert clear in the same cycle as a rise with key_code=7 -> digits=00, entry_count=0, no new_key. Holding the key then releasing produces no entry.
6. Assert rst mid-refresh, in the PRESSED state with count=2 -> all outputs return to reset values immediately (asynchronously, before the next clk edge). After deassert, the refresh restarts with chip_sel=0 at counter 0.
